// File: rtl/matrix_io_pkg.sv
// Shared definitions for the matrix processor result path.
//   - Default element / address widths of the processor data memory.
//   - Readout FSM state type used by matrix_result_reader.
package matrix_io_pkg;

  // Word and address width of the processor data memory.
  localparam int unsigned MATRIX_DATA_WIDTH = 8;
  localparam int unsigned MATRIX_ADDR_WIDTH = 12;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO that buffers returned memory words in front of the
// valid/ready output stream.
// Ports:
//   clk, rst    clock, synchronous active-high reset (flushes contents)
//   push        write push_data/push_last this cycle
//   push_data   element value to store
//   push_last   marks the final element of a readout
//   pop         remove the head entry this cycle
//   occupancy   number of stored entries (0..2)
//   head_valid  FIFO non-empty
//   head_data   data of the oldest entry
//   head_last   last flag of the oldest entry
module result_skid_fifo
  import matrix_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MATRIX_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            occupancy,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  do_push;
  logic                  do_pop;

  // Pop only when something is stored; a push into a full FIFO is only
  // accepted if the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
      end
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data;
        last_q[wr_ptr_q] <= push_last;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Head is only moved by a pop, so it stays stable while stalled.
  assign occupancy  = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = data_q[rd_ptr_q];
  assign head_last  = last_q[rd_ptr_q];

endmodule

// File: rtl/matrix_result_reader.sv
// Reads the ROWS x COLS result matrix (row-major, starting at BASE_ADDR)
// out of the synchronous data memory after the processor raises
// end_process, and streams it on a valid/ready interface.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   end_process  processor done level; rising edge starts a readout
//   mem_rd_en    memory read strobe (data returns one cycle later)
//   mem_addr     memory read address, holds its value between reads
//   mem_rdata    memory read data
//   out_data     streamed element
//   out_valid    out_data valid
//   out_ready    sink ready; transfer on out_valid && out_ready
//   out_last     marks element (ROWS-1, COLS-1)
//   busy         readout in progress
//   done         one-cycle pulse after the last element is accepted
module matrix_result_reader
  import matrix_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  end_process,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_ELEMS = ROWS * COLS;
  localparam int unsigned IDX_W     = $clog2(NUM_ELEMS + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_ELEMS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  if (NUM_ELEMS == 0) begin : g_bad_dims
    $error("matrix_result_reader: ROWS*COLS must be non-zero");
  end

  rd_state_t             state_q, state_d;
  logic                  end_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;

  logic [1:0]            fifo_occ;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_last;

  logic                  trigger;
  logic                  handshake;
  logic [1:0]            slots_used;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign trigger   = end_process && !end_q;
  assign handshake = fifo_valid && out_ready;

  // Credit check: buffered entries plus the read in flight must stay
  // below the FIFO depth. An entry leaving on this cycle's handshake
  // frees its slot before the issued read returns, which is what lets
  // the stream sustain one element per cycle. A handshake implies
  // fifo_occ >= 1, so the subtraction never wraps.
  assign slots_used = fifo_occ + {1'b0, inflight_q} - {1'b0, handshake};
  assign issue      = (state_q == READ) && (slots_used < 2'd2) && !rst;
  assign issue_last = (idx_q == LAST_IDX);
  assign cur_addr   = BASE + ADDR_WIDTH'(idx_q);

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? cur_addr : addr_hold_q;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    inflight_d      = issue;
    inflight_last_d = issue && issue_last;
    addr_hold_d     = issue ? cur_addr : addr_hold_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (issue_last) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (handshake && fifo_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      end_q           <= 1'b0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      addr_hold_q     <= '0;
    end else begin
      state_q         <= state_d;
      end_q           <= end_process;
      idx_q           <= idx_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      addr_hold_q     <= addr_hold_d;
    end
  end

  result_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (mem_rdata),
    .push_last  (inflight_last_q),
    .pop        (handshake),
    .occupancy  (fifo_occ),
    .head_valid (fifo_valid),
    .head_data  (fifo_data),
    .head_last  (fifo_last)
  );

  assign out_valid = fifo_valid;
  assign out_data  = fifo_data;
  assign out_last  = fifo_last;
  assign busy      = (state_q == READ) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_matrix_result_reader.sv
module tb_matrix_result_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: default geometry (4x4 at address 0)
  logic        end_a, rd_en_a, valid_a, ready_a, last_a, busy_a, done_a;
  logic [11:0] addr_a;
  logic [7:0]  rdata_a, data_a;
  // DUT B: 2x3 at address 100
  logic        end_b, rd_en_b, valid_b, ready_b, last_b, busy_b, done_b;
  logic [11:0] addr_b;
  logic [7:0]  rdata_b, data_b;

  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [4096];

  beat_t exp_a[$];
  beat_t exp_b[$];

  int checks   = 0;
  int failures = 0;

  matrix_result_reader u_dut_a (
    .clk(clk), .rst(rst), .end_process(end_a),
    .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  matrix_result_reader #(
    .BASE_ADDR(100), .ROWS(2), .COLS(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .end_process(end_b),
    .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  // Synchronous RAM models: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= mem_a[addr_a];
    if (rd_en_b) rdata_b <= mem_b[addr_b];
  end

  function automatic logic [7:0] val_b(input int i);
    return 8'(8'h40 + 7 * i);
  endfunction

  task automatic push_exp_a();
    for (int i = 0; i < 16; i++) exp_a.push_back('{data: 8'(3 * i), last: (i == 15)});
  endtask

  task automatic push_exp_b();
    for (int i = 0; i < 6; i++) exp_b.push_back('{data: val_b(i), last: (i == 5)});
  endtask

  task automatic test_reset();
    rst = 1'b1; end_a = 1'b0; end_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rd_en_a, addr_a, data_a, valid_a, last_a, busy_a, done_a} !== '0) begin
      failures++;
      $display("FAIL reset_a: got rd=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b, required all 0",
               rd_en_a, addr_a, data_a, valid_a, last_a, busy_a, done_a);
    end
    checks++;
    if ({rd_en_b, addr_b, data_b, valid_b, last_b, busy_b, done_b} !== '0) begin
      failures++;
      $display("FAIL reset_b: got rd=%b addr=%0d data=%0d v=%b busy=%b done=%b, required all 0",
               rd_en_b, addr_b, data_b, valid_b, busy_b, done_b);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rd_en_a, valid_a, busy_a, done_a} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got rd=%b v=%b busy=%b done=%b, required 0",
               rd_en_a, valid_a, busy_a, done_a);
    end
  endtask

  task automatic test_basic();
    int first_k = -1, last_k = -1, done_k = -1, dones = 0, beats = 0;
    beat_t got, exp;
    push_exp_a();
    @(negedge clk); end_a = 1'b1; ready_a = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) end_a = 1'b0;
      #1;
      if (k == 1) begin
        checks++;
        if (busy_a !== 1'b1) begin
          failures++; $display("FAIL basic_busy: got %b required 1", busy_a);
        end
      end
      if (valid_a && first_k < 0) first_k = k;
      if (done_a) begin dones++; if (done_k < 0) done_k = k; end
      if (valid_a && ready_a) begin
        got = '{data: data_a, last: last_a};
        exp = (exp_a.size() > 0) ? exp_a.pop_front() : '{data: 8'hxx, last: 1'bx};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL basic_beat%0d: got data=%0d last=%b required data=%0d last=%b",
                   beats, got.data, got.last, exp.data, exp.last);
        end
        beats++; last_k = k;
      end
    end
    checks++;
    if (first_k != 3) begin failures++; $display("FAIL basic_latency: got %0d required 3", first_k); end
    checks++;
    if (beats != 16 || last_k - first_k != 15) begin
      failures++; $display("FAIL basic_consecutive: got beats=%0d span=%0d required 16/15", beats, last_k - first_k);
    end
    checks++;
    if (dones != 1 || done_k != last_k + 1) begin
      failures++; $display("FAIL basic_done: got count=%0d at %0d required 1 at %0d", dones, done_k, last_k + 1);
    end
  endtask

  task automatic test_backpressure();
    int buf_cnt = 0, infl = 0, issued = 0, beats = 0;
    bit acc, prev_stall = 0, done_seen = 0;
    beat_t prev = '0, got, exp;
    push_exp_a();
    @(negedge clk); end_a = 1'b1; ready_a = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      ready_a = (k % 4 == 0) || (k % 4 == 3);
      if (k == 3) end_a = 1'b0;
      #1;
      acc = valid_a && ready_a;
      checks++;
      if (valid_a !== (buf_cnt != 0)) begin
        failures++; $display("FAIL bp_valid k=%0d: got %b required %b", k, valid_a, buf_cnt != 0);
      end
      if (rd_en_a) begin
        checks++;
        if (buf_cnt + infl - int'(acc) >= 2) begin
          failures++; $display("FAIL bp_credit k=%0d: got rd_en with buf=%0d infl=%0d acc=%0d", k, buf_cnt, infl, acc);
        end
        checks++;
        if (addr_a !== 12'(issued)) begin
          failures++; $display("FAIL bp_addr: got %0d required %0d", addr_a, issued);
        end
        issued++;
      end
      if (prev_stall) begin
        checks++;
        if ({data_a, last_a} !== prev) begin
          failures++; $display("FAIL bp_stable k=%0d: got %0d required %0d", k, data_a, prev.data);
        end
      end
      if (acc) begin
        got = '{data: data_a, last: last_a};
        exp = (exp_a.size() > 0) ? exp_a.pop_front() : '{data: 8'hxx, last: 1'bx};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL bp_beat%0d: got %0d/%b required %0d/%b", beats, got.data, got.last, exp.data, exp.last);
        end
        beats++;
      end
      prev_stall = valid_a && !ready_a;
      prev = '{data: data_a, last: last_a};
      buf_cnt = buf_cnt + infl - int'(acc);
      infl = int'(rd_en_a);
      if (done_a) begin done_seen = 1; break; end
    end
    checks++;
    if (!done_seen || beats != 16 || issued != 16 || exp_a.size() != 0) begin
      failures++; $display("FAIL bp_total: got done=%b beats=%0d reads=%0d left=%0d required 1/16/16/0",
                           done_seen, beats, issued, exp_a.size());
    end
    ready_a = 1'b1;
  endtask

  task automatic test_long_stall();
    int addrs[$];
    int beats = 0, reads = 0;
    bit done_seen = 0;
    beat_t got, exp;
    push_exp_a();
    @(negedge clk); end_a = 1'b1; ready_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) end_a = 1'b0;
      #1;
      if (rd_en_a) addrs.push_back(int'(addr_a));
    end
    checks++;
    if (addrs.size() != 2) begin
      failures++; $display("FAIL stall_reads: got %0d required 2", addrs.size());
    end else begin
      checks++;
      if (addrs[0] != 0 || addrs[1] != 1) begin
        failures++; $display("FAIL stall_addrs: got %0d,%0d required 0,1", addrs[0], addrs[1]);
      end
    end
    checks++;
    if (valid_a !== 1'b1 || data_a !== 8'd0) begin
      failures++; $display("FAIL stall_head: got v=%b data=%0d required 1/0", valid_a, data_a);
    end
    reads = addrs.size();
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); ready_a = 1'b1; #1;
      if (rd_en_a) reads++;
      if (valid_a && ready_a) begin
        got = '{data: data_a, last: last_a};
        exp = (exp_a.size() > 0) ? exp_a.pop_front() : '{data: 8'hxx, last: 1'bx};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL stall_beat%0d: got %0d/%b required %0d/%b", beats, got.data, got.last, exp.data, exp.last);
        end
        beats++;
      end
      if (done_a) begin done_seen = 1; break; end
    end
    checks++;
    if (!done_seen || beats != 16 || reads != 16) begin
      failures++; $display("FAIL stall_total: got done=%b beats=%0d reads=%0d required 1/16/16", done_seen, beats, reads);
    end
  endtask

  task automatic test_level_hold();
    beat_t got, exp;
    for (int rep = 0; rep < 2; rep++) begin
      int reads = 0, beats = 0, dones = 0;
      push_exp_b();
      @(negedge clk); end_b = 1'b1; ready_b = 1'b1;
      for (int k = 1; k <= 70; k++) begin
        @(negedge clk);
        if ((rep == 0 && k == 50) || (rep == 1 && k == 2)) end_b = 1'b0;
        #1;
        if (rd_en_b) begin
          checks++;
          if (addr_b !== 12'(100 + reads)) begin
            failures++; $display("FAIL hold_addr rep%0d: got %0d required %0d", rep, addr_b, 100 + reads);
          end
          reads++;
        end
        if (valid_b && ready_b) begin
          got = '{data: data_b, last: last_b};
          exp = (exp_b.size() > 0) ? exp_b.pop_front() : '{data: 8'hxx, last: 1'bx};
          checks++;
          if (got !== exp) begin
            failures++; $display("FAIL hold_beat rep%0d: got %0d/%b required %0d/%b", rep, got.data, got.last, exp.data, exp.last);
          end
          beats++;
        end
        if (done_b) dones++;
      end
      checks++;
      if (reads != 6 || beats != 6 || dones != 1) begin
        failures++; $display("FAIL hold_once rep%0d: got reads=%0d beats=%0d dones=%0d required 6/6/1", rep, reads, beats, dones);
      end
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0, reads = 0;
    bit done_seen = 0, bad_idle = 0, first_rd = 1;
    beat_t got, exp;
    push_exp_a();
    @(negedge clk); end_a = 1'b1; ready_a = 1'b1;
    for (int k = 1; k <= 40 && beats < 5; k++) begin
      @(negedge clk);
      if (k == 3) end_a = 1'b0;
      #1;
      if (valid_a && ready_a) begin
        got = '{data: data_a, last: last_a};
        exp = (exp_a.size() > 0) ? exp_a.pop_front() : '{data: 8'hxx, last: 1'bx};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL rmid_beat%0d: got %0d required %0d", beats, got.data, exp.data);
        end
        beats++;
      end
    end
    end_a = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if ({rd_en_a, addr_a, data_a, valid_a, last_a, busy_a, done_a} !== '0) begin
      failures++;
      $display("FAIL rmid_outputs: got rd=%b addr=%0d data=%0d v=%b l=%b busy=%b done=%b, required all 0",
               rd_en_a, addr_a, data_a, valid_a, last_a, busy_a, done_a);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (done_a || valid_a || rd_en_a || busy_a) bad_idle = 1;
    end
    checks++;
    if (bad_idle) begin failures++; $display("FAIL rmid_quiet: got activity after reset, required none"); end
    exp_a.delete();
    push_exp_a();
    beats = 0;
    @(negedge clk); end_a = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 3) end_a = 1'b0;
      #1;
      if (rd_en_a) begin
        if (first_rd) begin
          checks++;
          if (addr_a !== 12'd0) begin failures++; $display("FAIL rmid_restart_addr: got %0d required 0", addr_a); end
          first_rd = 0;
        end
        reads++;
      end
      if (valid_a && ready_a) begin
        got = '{data: data_a, last: last_a};
        exp = (exp_a.size() > 0) ? exp_a.pop_front() : '{data: 8'hxx, last: 1'bx};
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL rmid_rbeat%0d: got %0d/%b required %0d/%b", beats, got.data, got.last, exp.data, exp.last);
        end
        beats++;
      end
      if (done_a) begin done_seen = 1; break; end
    end
    checks++;
    if (!done_seen || beats != 16 || reads != 16) begin
      failures++; $display("FAIL rmid_total: got done=%b beats=%0d reads=%0d required 1/16/16", done_seen, beats, reads);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = (i < 16) ? 8'(3 * i) : 8'hA5;
      mem_b[i] = 8'hA5;
    end
    for (int i = 0; i < 6; i++) mem_b[100 + i] = val_b(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_long_stall();
    test_level_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
